// File: rtl/ps2_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// ps2_pkg: shared types and constants for the PS/2 receive path.
// Revision: 1.0
// ----------------------------------------------------------------------------
package ps2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } ps2_state_e;

  localparam logic [7:0] PS2_EXT = 8'hE0;
  localparam logic [7:0] PS2_BRK = 8'hF0;

  localparam int EV_W        = 10;
  localparam int EV_CODE_LSB = 0;
  localparam int EV_CODE_MSB = 7;
  localparam int EV_BRK_BIT  = 8;
  localparam int EV_EXT_BIT  = 9;

  function automatic logic [EV_W-1:0] pack_event(input logic [7:0] code,
                                                 input logic       brk,
                                                 input logic       ext);
    return {ext, brk, code};
  endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_event_fifo.sv
`default_nettype none
// ----------------------------------------------------------------------------
// ps2_event_fifo: synchronous event FIFO with registered head outputs.
// Revision: 1.0
// ----------------------------------------------------------------------------
module ps2_event_fifo
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_push,
  input  logic [EV_W-1:0] i_push_data,
  input  logic            i_pop,
  output logic            o_full,
  output logic            o_empty,
  output logic            o_head_valid,
  output logic [EV_W-1:0] o_head_data
);

  localparam int c_PTR_W = $clog2(FIFO_DEPTH);
  localparam int c_CNT_W = c_PTR_W + 1;

  logic [EV_W-1:0]    r_mem [FIFO_DEPTH];
  logic [c_PTR_W-1:0] r_wr_ptr;
  logic [c_PTR_W-1:0] r_rd_ptr;
  logic [c_CNT_W-1:0] r_count;
  logic               r_head_valid;
  logic [EV_W-1:0]    r_head_data;

  logic               w_pop;
  logic               w_push;
  logic [c_CNT_W-1:0] w_count_kept;
  logic [c_CNT_W-1:0] w_count_nxt;
  logic [c_PTR_W-1:0] w_rd_nxt;

  assign o_full       = (r_count == c_CNT_W'(FIFO_DEPTH));
  assign o_empty      = (r_count == '0);
  assign w_pop        = i_pop & r_head_valid;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign w_push       = i_push & (~o_full | w_pop);
  assign w_count_kept = r_count - c_CNT_W'(w_pop);
  assign w_count_nxt  = w_count_kept + c_CNT_W'(w_push);
  assign w_rd_nxt     = r_rd_ptr + c_PTR_W'(w_pop);

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_push_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_head_valid <= 1'b0;
      r_head_data  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
      end
      r_rd_ptr     <= w_rd_nxt;
      r_count      <= w_count_nxt;
      r_head_valid <= (w_count_nxt != '0);
      // Head comes from the incoming word when nothing older survives the pop.
      if (w_count_nxt == '0) begin
        r_head_data <= '0;
      end else if (w_count_kept == '0) begin
        r_head_data <= i_push_data;
      end else begin
        r_head_data <= r_mem[w_rd_nxt];
      end
    end
  end

  assign o_head_valid = r_head_valid;
  assign o_head_data  = r_head_data;

endmodule
`default_nettype wire

// File: rtl/ps2_scan_sequencer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// ps2_scan_sequencer: PS/2 frame receiver folding E0/F0 prefixes into key events.
// Revision: 1.0
// ----------------------------------------------------------------------------
module ps2_scan_sequencer
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYC = 100000,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic       CLOCK_50,
  input  logic       Resetn,
  input  logic       PS2_CLK,
  input  logic       PS2_DAT,
  output logic       ev_valid,
  input  logic       ev_ready,
  output logic [7:0] ev_code,
  output logic       ev_break,
  output logic       ev_ext,
  output logic       frame_err,
  output logic       overflow,
  output logic       busy
);

  localparam int                 c_TMO_W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [c_TMO_W-1:0] c_TMO_LAST = c_TMO_W'(TIMEOUT_CYC - 1);

  logic [1:0]         r_clk_sync;
  logic [1:0]         r_dat_sync;
  logic               r_clk_prev;
  ps2_state_e         r_state;
  logic [2:0]         r_bit_cnt;
  logic [7:0]         r_shift;
  logic               r_parity;
  logic [c_TMO_W-1:0] r_tmo_cnt;
  logic               r_ext_pend;
  logic               r_brk_pend;
  logic               r_frame_err;
  logic               r_push;
  logic [EV_W-1:0]    r_push_data;
  logic               r_overflow;

  ps2_state_e         w_state_nxt;
  logic [2:0]         w_bit_nxt;
  logic [7:0]         w_shift_nxt;
  logic               w_par_nxt;
  logic [c_TMO_W-1:0] w_tmo_nxt;
  logic               w_ext_nxt;
  logic               w_brk_nxt;
  logic               w_err_nxt;
  logic               w_push_nxt;
  logic [EV_W-1:0]    w_pdata_nxt;

  logic               w_fall;
  logic               w_dat;
  logic               w_frame_ok;
  logic               w_fifo_full;
  logic               w_fifo_empty;
  logic [EV_W-1:0]    w_head;

  assign w_fall     = r_clk_prev & ~r_clk_sync[1];
  assign w_dat      = r_dat_sync[1];
  assign w_frame_ok = (^{r_shift, r_parity}) & w_dat;

  always_ff @(posedge CLOCK_50 or negedge Resetn) begin
    if (!Resetn) begin
      r_clk_sync  <= 2'b11;
      r_dat_sync  <= 2'b11;
      r_clk_prev  <= 1'b1;
      r_state     <= ST_IDLE;
      r_bit_cnt   <= '0;
      r_shift     <= '0;
      r_parity    <= 1'b0;
      r_tmo_cnt   <= '0;
      r_ext_pend  <= 1'b0;
      r_brk_pend  <= 1'b0;
      r_frame_err <= 1'b0;
      r_push      <= 1'b0;
      r_push_data <= '0;
    end else begin
      r_clk_sync  <= {r_clk_sync[0], PS2_CLK};
      r_dat_sync  <= {r_dat_sync[0], PS2_DAT};
      r_clk_prev  <= r_clk_sync[1];
      r_state     <= w_state_nxt;
      r_bit_cnt   <= w_bit_nxt;
      r_shift     <= w_shift_nxt;
      r_parity    <= w_par_nxt;
      r_tmo_cnt   <= w_tmo_nxt;
      r_ext_pend  <= w_ext_nxt;
      r_brk_pend  <= w_brk_nxt;
      r_frame_err <= w_err_nxt;
      r_push      <= w_push_nxt;
      r_push_data <= w_pdata_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_bit_nxt   = r_bit_cnt;
    w_shift_nxt = r_shift;
    w_par_nxt   = r_parity;
    w_tmo_nxt   = r_tmo_cnt + c_TMO_W'(1);
    w_ext_nxt   = r_ext_pend;
    w_brk_nxt   = r_brk_pend;
    w_err_nxt   = 1'b0;
    w_push_nxt  = 1'b0;
    w_pdata_nxt = r_push_data;

    if (w_fall) begin
      w_tmo_nxt = '0;
    end

    case (r_state)
      ST_IDLE: begin
        w_tmo_nxt = '0;
        if (w_fall && !w_dat) begin
          w_state_nxt = ST_DATA;
          w_bit_nxt   = '0;
        end
      end
      ST_DATA: begin
        if (w_fall) begin
          w_shift_nxt = {w_dat, r_shift[7:1]};
          w_bit_nxt   = r_bit_cnt + 3'd1;
          if (r_bit_cnt == 3'd7) begin
            w_state_nxt = ST_PARITY;
          end
        end
      end
      ST_PARITY: begin
        if (w_fall) begin
          w_par_nxt   = w_dat;
          w_state_nxt = ST_STOP;
        end
      end
      ST_STOP: begin
        if (w_fall) begin
          w_state_nxt = ST_IDLE;
          if (!w_frame_ok) begin
            w_err_nxt = 1'b1;
            w_ext_nxt = 1'b0;
            w_brk_nxt = 1'b0;
          end else if (r_shift == PS2_EXT) begin
            w_ext_nxt = 1'b1;
          end else if (r_shift == PS2_BRK) begin
            w_brk_nxt = 1'b1;
          end else begin
            w_push_nxt  = 1'b1;
            w_pdata_nxt = pack_event(r_shift, r_brk_pend, r_ext_pend);
            w_ext_nxt   = 1'b0;
            w_brk_nxt   = 1'b0;
          end
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase

    // A stalled frame is abandoned along with any prefix it was completing.
    if ((r_state != ST_IDLE) && !w_fall && (r_tmo_cnt == c_TMO_LAST)) begin
      w_state_nxt = ST_IDLE;
      w_tmo_nxt   = '0;
      w_err_nxt   = 1'b1;
      w_ext_nxt   = 1'b0;
      w_brk_nxt   = 1'b0;
    end
  end

  ps2_event_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk          (CLOCK_50),
    .rst_n        (Resetn),
    .i_push       (r_push),
    .i_push_data  (r_push_data),
    .i_pop        (ev_ready),
    .o_full       (w_fifo_full),
    .o_empty      (w_fifo_empty),
    .o_head_valid (ev_valid),
    .o_head_data  (w_head)
  );

  always_ff @(posedge CLOCK_50 or negedge Resetn) begin
    if (!Resetn) begin
      r_overflow <= 1'b0;
    end else if (r_push && w_fifo_full && !(ev_ready && !w_fifo_empty)) begin
      r_overflow <= 1'b1;
    end
  end

  assign ev_code   = w_head[EV_CODE_MSB:EV_CODE_LSB];
  assign ev_break  = w_head[EV_BRK_BIT];
  assign ev_ext    = w_head[EV_EXT_BIT];
  assign frame_err = r_frame_err;
  assign overflow  = r_overflow;
  assign busy      = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_ps2_scan_sequencer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_ps2_scan_sequencer: byte-level reference model bench for ps2_scan_sequencer.
// Revision: 1.0
// ----------------------------------------------------------------------------
module tb_ps2_scan_sequencer;

  localparam int TIMEOUT_CYC = 64;
  localparam int FIFO_DEPTH  = 4;
  localparam int H           = 8;

  logic       CLOCK_50 = 1'b0;
  logic       Resetn   = 1'b0;
  logic       PS2_CLK  = 1'b1;
  logic       PS2_DAT  = 1'b1;
  logic       ev_ready = 1'b0;
  logic       ev_valid;
  logic [7:0] ev_code;
  logic       ev_break;
  logic       ev_ext;
  logic       frame_err;
  logic       overflow;
  logic       busy;

  ps2_scan_sequencer #(
    .TIMEOUT_CYC (TIMEOUT_CYC),
    .FIFO_DEPTH  (FIFO_DEPTH)
  ) dut (
    .CLOCK_50  (CLOCK_50),
    .Resetn    (Resetn),
    .PS2_CLK   (PS2_CLK),
    .PS2_DAT   (PS2_DAT),
    .ev_valid  (ev_valid),
    .ev_ready  (ev_ready),
    .ev_code   (ev_code),
    .ev_break  (ev_break),
    .ev_ext    (ev_ext),
    .frame_err (frame_err),
    .overflow  (overflow),
    .busy      (busy)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  int         checks = 0;
  int         errors = 0;
  logic [9:0] exp_q[$];
  logic [9:0] cmp_e;
  bit         m_ext, m_brk, exp_ovf;
  int         exp_err = 0, err_seen = 0;
  int         tick_no = 0, fall_tick = 0, valid_rise = 0, err_rise = 0;
  bit         last_valid, last_err, prev_err, rand_ready;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge CLOCK_50);
    #1;
    tick_no++;
    if (rand_ready) ev_ready = 1'($urandom_range(0, 1));
    if (ev_valid && !last_valid) valid_rise = tick_no;
    if (frame_err && !last_err) err_rise = tick_no;
    last_valid = ev_valid;
    last_err   = frame_err;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  // Byte-level reference: prefixes accumulate, any other good byte becomes one event.
  function automatic void model_byte(input logic [7:0] b, input bit good);
    if (!good) begin
      exp_err++;
      m_ext = 1'b0;
      m_brk = 1'b0;
    end else if (b == 8'hE0) begin
      m_ext = 1'b1;
    end else if (b == 8'hF0) begin
      m_brk = 1'b1;
    end else begin
      if (exp_q.size() >= FIFO_DEPTH) exp_ovf = 1'b1;
      else exp_q.push_back({m_ext, m_brk, b});
      m_ext = 1'b0;
      m_brk = 1'b0;
    end
  endfunction

  // Partial frames (nfalls < 11) return with PS2_CLK still low after the last fall.
  task automatic send_frame(input logic [7:0] b, input bit par_flip, input bit stop, input int nfalls);
    logic [10:0] bits;
    logic        par;
    par  = ~(^b) ^ par_flip;
    bits = {stop, par, b, 1'b0};
    for (int i = 0; i < nfalls; i++) begin
      PS2_DAT = bits[i];
      ticks(H);
      PS2_CLK   = 1'b0;
      fall_tick = tick_no;
      if (i == 10) model_byte(b, !par_flip && stop);
      if (i != nfalls - 1 || nfalls == 11) begin
        ticks(H);
        PS2_CLK = 1'b1;
      end
    end
    if (nfalls == 11) begin
      PS2_DAT = 1'b1;
      ticks(2 * H);
    end
  endtask

  task automatic send(input logic [7:0] b);
    send_frame(b, 1'b0, 1'b1, 11);
  endtask

  task automatic expect_head(input logic [7:0] code, input bit brk, input bit ext, input string name);
    int k;
    k = 0;
    while (!ev_valid && k < 50) begin
      tick();
      k++;
    end
    check({name, "_valid"}, ev_valid, 1);
    check({name, "_event"}, {ev_ext, ev_break, ev_code}, {ext, brk, code});
    ev_ready = 1'b1;
    tick();
    ev_ready = 1'b0;
  endtask

  task automatic drain(input string name);
    int k;
    rand_ready = 1'b0;
    ev_ready   = 1'b1;
    k = 0;
    while ((exp_q.size() != 0 || ev_valid) && k < 300) begin
      tick();
      k++;
    end
    ev_ready = 1'b0;
    check({name, "_pending"}, exp_q.size(), 0);
    check({name, "_valid"}, ev_valid, 0);
    check({name, "_errcount"}, err_seen, exp_err);
    check({name, "_overflow"}, overflow, exp_ovf);
    check({name, "_busy"}, busy, 0);
  endtask

  // Per-cycle compare against the reference queue and frame_err pulse shape.
  always @(negedge CLOCK_50) begin
    if (Resetn) begin
      if (frame_err) begin
        err_seen++;
        checks++;
        if (prev_err) begin
          errors++;
          $display("FAIL frame_err_width: high for 2+ cycles, expected 1");
        end
      end
      prev_err = frame_err;
      if (ev_valid && ev_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL event_unexpected: got %h, expected none", {ev_ext, ev_break, ev_code});
        end else begin
          cmp_e = exp_q.pop_front();
          if ({ev_ext, ev_break, ev_code} !== cmp_e) begin
            errors++;
            $display("FAIL event_mismatch: got %h, expected %h", {ev_ext, ev_break, ev_code}, cmp_e);
          end
        end
      end
    end else begin
      prev_err = 1'b0;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int   t0, k, d, e0;
    logic [7:0] b;
    logic [7:0] lit [4];

    ticks(4);
    check("rst_valid", ev_valid, 0);
    check("rst_code", ev_code, 0);
    check("rst_break", ev_break, 0);
    check("rst_ext", ev_ext, 0);
    check("rst_frame_err", frame_err, 0);
    check("rst_overflow", overflow, 0);
    check("rst_busy", busy, 0);
    Resetn = 1'b1;
    ticks(4);

    // Plain make code, with latency from the stop-bit edge through the synchroniser.
    send(8'h1C);
    check("t1_latency", valid_rise - fall_tick, 4);
    check("t1_no_err", err_seen, 0);
    expect_head(8'h1C, 1'b0, 1'b0, "t1");

    send(8'hF0); send(8'h1C);
    expect_head(8'h1C, 1'b1, 1'b0, "t2");

    send(8'hE0); send(8'hF0); send(8'h75);
    expect_head(8'h75, 1'b1, 1'b1, "t3");
    send(8'h1C);
    expect_head(8'h1C, 1'b0, 1'b0, "t3_after");

    // Parity error discards the pending break prefix.
    send(8'hF0);
    send_frame(8'h1C, 1'b1, 1'b1, 11);
    check("t4_err_delay", err_rise - fall_tick, 3);
    check("t4_err_count", err_seen, 1);
    check("t4_no_event", ev_valid, 0);
    send(8'h1C);
    expect_head(8'h1C, 1'b0, 1'b0, "t4_after");
    send_frame(8'h5A, 1'b0, 1'b0, 11);
    check("t4_stop_err", err_seen, 2);
    drain("t4");

    // Stalled frame after an E0 prefix.
    send(8'hE0);
    send_frame(8'h00, 1'b0, 1'b1, 4);
    ticks(2);
    check("t6_busy_mid", busy, 1);
    t0 = fall_tick;
    k  = 0;
    while (err_rise <= t0 && k < TIMEOUT_CYC + 20) begin
      tick();
      k++;
      if (k == H) PS2_CLK = 1'b1;
    end
    PS2_CLK = 1'b1;
    exp_err++;
    m_ext = 1'b0;
    m_brk = 1'b0;
    d = err_rise - t0;
    checks++;
    if (d != TIMEOUT_CYC + 2 && d != TIMEOUT_CYC + 3) begin
      errors++;
      $display("FAIL timeout_delay: got %0d cycles, expected %0d or %0d", d, TIMEOUT_CYC + 2, TIMEOUT_CYC + 3);
    end
    tick();
    check("t6_busy_after", busy, 0);
    send(8'h23);
    expect_head(8'h23, 1'b0, 1'b0, "t6");

    // Overflow with the consumer stalled.
    lit[0] = 8'h15; lit[1] = 8'h1D; lit[2] = 8'h24; lit[3] = 8'h2D;
    send(8'h15); send(8'h1D); send(8'h24); send(8'h2D);
    check("t5_no_ovf_yet", overflow, 0);
    send(8'h2C);
    ticks(4);
    check("t5_overflow", overflow, 1);
    ev_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("t5_burst_valid", ev_valid, 1);
      check("t5_burst_code", ev_code, lit[i]);
      tick();
    end
    check("t5_valid_drop", ev_valid, 0);
    ev_ready = 1'b0;
    drain("t5");

    // Reset in the middle of a frame with a pending prefix.
    send(8'hE0);
    send_frame(8'h00, 1'b0, 1'b1, 4);
    ticks(H);
    PS2_CLK = 1'b1;
    ticks(2);
    check("t6r_busy_mid", busy, 1);
    Resetn = 1'b0;
    ticks(3);
    Resetn = 1'b1;
    m_ext   = 1'b0;
    m_brk   = 1'b0;
    exp_ovf = 1'b0;
    exp_q.delete();
    check("t6r_overflow", overflow, 0);
    check("t6r_busy", busy, 0);
    e0 = err_seen;
    ticks(TIMEOUT_CYC + 20);
    check("t6r_no_err", err_seen, e0);
    send(8'h23);
    expect_head(8'h23, 1'b0, 1'b0, "t6r");

    // Randomised traffic: prefixes, codes, bad frames, stray edges, random back-pressure.
    rand_ready = 1'b1;
    for (int n = 0; n < 40; n++) begin
      k = $urandom_range(0, 99);
      if (k < 15) begin
        send(8'hE0);
      end else if (k < 30) begin
        send(8'hF0);
      end else if (k < 36) begin
        PS2_DAT = 1'b1;
        ticks(2);
        PS2_CLK = 1'b0;
        ticks(H);
        PS2_CLK = 1'b1;
        ticks(H);
      end else begin
        b = 8'($urandom_range(1, 255));
        if (b == 8'hE0 || b == 8'hF0) b = 8'h1C;
        send_frame(b, ($urandom_range(0, 9) == 0), ($urandom_range(0, 14) != 0), 11);
      end
      ticks($urandom_range(0, 20));
    end
    drain("random");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ps2_scan_sequencer.md
Name: ps2_scan_sequencer

Overview:
Frame-level controller for the PS/2 keyboard receive path. It samples PS2_CLK/PS2_DAT, runs the 11-bit frame FSM with parity/stop checking and a stall timeout, and folds E0 (extended) and F0 (break) prefix bytes into single key events. Events go through a small FIFO with a valid/ready handshake, so downstream consumers (key-type classifier, HEX display logic, game logic) read one event per key action instead of raw shifted bits.

Parameters:
TIMEOUT_CYC, 100000, idle CLOCK_50 cycles allowed between PS/2 falling edges inside a frame (2 ms at 50 MHz) before the frame is aborted.
FIFO_DEPTH, 4, number of event entries buffered. Must be a power of two, 2 or greater.

Ports:
CLOCK_50  in  1  system clock, 50 MHz.
Resetn  in  1  asynchronous, active-low reset.
PS2_CLK  in  1  raw PS/2 clock from the pad. Asynchronous to CLOCK_50.
PS2_DAT  in  1  raw PS/2 data from the pad. Asynchronous to CLOCK_50.
ev_valid  out  1  FIFO head holds an event.
ev_ready  in  1  consumer accepts the head event.
ev_code  out  8  scan code of the head event.
ev_break  out  1  head event is a key release (F0-prefixed).
ev_ext  out  1  head event is extended (E0-prefixed).
frame_err  out  1  one-cycle pulse on a parity, stop or timeout error.
overflow  out  1  sticky flag: an event was dropped because the FIFO was full. Cleared only by reset.
busy  out  1  frame FSM is not in IDLE.

Behaviour:
- Reset: asynchronous on Resetn=0. Effects:
  - FSM to IDLE; bit counter, shift register, timeout counter, ext_pend and brk_pend all 0.
  - FIFO empty.
  - ev_valid=0, ev_code=0, ev_break=0, ev_ext=0, frame_err=0, overflow=0, busy=0.
  - Synchroniser flops reset to 1 (bus idle high).
- Input sampling:
  - Two-flop synchroniser on each PS/2 line.
  - fall = previous synced clock is 1 and current synced clock is 0.
  - All PS/2 data sampling happens only in cycles where fall=1.
- Frame FSM: states IDLE, DATA, PARITY, STOP.
  - IDLE: on fall with data=0 (start bit), go to DATA with bit count 0. On fall with data=1, stay in IDLE; no error.
  - DATA: on fall, shift the data bit in LSB-first. After the 8th bit, go to PARITY.
  - PARITY: on fall, capture the parity bit and go to STOP.
  - STOP: on fall, the frame is good only if (XOR of the 8 data bits and the parity bit) = 1 (odd parity) and the stop bit = 1.
    - Good frame: byte handling runs in the same cycle; FSM returns to IDLE.
    - Bad frame: frame_err pulses high next cycle; ext_pend and brk_pend clear; FSM returns to IDLE.
- Timeout:
  - The counter clears on every fall and increments every cycle while the FSM is not in IDLE.
  - At count = TIMEOUT_CYC-1: FSM goes to IDLE, frame_err pulses, ext_pend and brk_pend clear.
- Byte handling (good frame only):
  - 0xE0: set ext_pend; no event.
  - 0xF0: set brk_pend; no event.
  - Any other byte: push {code, brk_pend, ext_pend} into the FIFO, then clear both pend flags.
- FIFO:
  - Entries are 10 bits. ev_* outputs are driven from the head entry, registered.
  - Pop occurs when ev_valid and ev_ready are both 1.
  - Push while empty: ev_valid rises the cycle after the push (no bypass).
  - Latency: ev_valid is high 2 cycles after the cycle in which the stop-bit fall is detected.
  - Push while full with no pop: the new event is dropped and overflow is set. Existing entries are unchanged.
  - Push and pop in the same cycle while full: both take effect; nothing is dropped.
  - Pointer wrap-around is modulo FIFO_DEPTH, with a separate count.
  - ev_ready is ignored while ev_valid=0.
- Reset mid-frame: the partial frame and any pending prefix are discarded. The next start bit begins a fresh frame.

Decomposition:
- Package ps2_pkg:
  - FSM state enum.
  - Constants PS2_EXT=8'hE0, PS2_BRK=8'hF0.
  - Event width EV_W=10 and field positions (code [7:0], break [8], ext [9]).
- Sub-module ps2_event_fifo: synchronous FIFO with parameter FIFO_DEPTH, push/pop/full/empty and registered head outputs. It is instantiated once.

Test Plan:
1. Frame for 0x1C: start 0, data bits 0,0,1,1,1,0,0,0, parity 0, stop 1 -> one event with ev_code=8'h1C, ev_break=0, ev_ext=0; frame_err stays 0.
2. Bytes F0 then 1C -> exactly one event: code=8'h1C, break=1, ext=0.
3. Bytes E0, F0, 75 -> exactly one event: code=8'h75, break=1, ext=1. A following 8'h1C event has break=0, ext=0.
4. F0, then 0x1C with parity bit 1 -> frame_err is high for exactly 1 cycle and no event is produced. A following good 0x1C gives break=0 (prefix was cleared).
5. ev_ready=0, then send 5 make codes 15,1D,24,2D,2C -> overflow=1 after the 5th. Then ev_ready=1 -> 15,1D,24,2D are delivered in order, one per cycle, and ev_valid drops after the 4th.
6. Start bit plus 3 data bits, then PS2_CLK held high -> frame_err pulses TIMEOUT_CYC cycles after the last fall and busy=0. A following full frame 0x23 decodes correctly. Repeat the test with Resetn pulsed mid-frame instead: no frame_err, and the next frame decodes correctly.
